// File: rtl/sd_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_rw_arbiter
// Brief    : Round-robin arbiter sharing one SD read/write controller between
//            a sector-write requester and a sector-read requester.
// Revision : 1.0 - initial release
// ============================================================================
module sd_rw_arbiter #(
    parameter logic [15:0] START_WAIT_MAX = 16'd1000,
    parameter logic [23:0] BUSY_WAIT_MAX  = 24'd5_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        req_wr,
    input  logic [31:0] req_wr_addr,
    input  logic        req_rd,
    input  logic [31:0] req_rd_addr,
    output logic        sd_wr_en,
    output logic [31:0] sd_wr_addr,
    input  logic        sd_wr_busy,
    output logic        sd_rd_en,
    output logic [31:0] sd_rd_addr,
    input  logic        sd_rd_busy,
    output logic        wr_done,
    output logic        wr_err,
    output logic        rd_done,
    output logic        rd_err,
    output logic        arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_ACK_WAIT  = 3'd2,
        S_BUSY_WAIT = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic        c_WRITE      = 1'b0;
    localparam logic        c_READ       = 1'b1;
    localparam logic [23:0] c_START_LAST = {8'd0, START_WAIT_MAX} - 24'd1;
    localparam logic [23:0] c_BUSY_LAST  = BUSY_WAIT_MAX - 24'd1;

    state_t      state_q;
    logic        sel_q;
    logic        last_grant_q;
    logic [23:0] cnt_q;
    logic        wr_busy_q;
    logic        rd_busy_q;
    logic        sd_wr_en_q;
    logic        sd_rd_en_q;
    logic [31:0] sd_wr_addr_q;
    logic [31:0] sd_rd_addr_q;
    logic        wr_done_q;
    logic        wr_err_q;
    logic        rd_done_q;
    logic        rd_err_q;
    logic        arb_busy_q;

    logic w_grant_ok;
    logic w_pick_wr;
    logic w_sel_busy;
    logic w_sel_busy_q;
    logic w_rise;
    logic w_fall;

    // New grants wait for the controller to be fully idle on both sides.
    assign w_grant_ok   = init_end & ~sd_wr_busy & ~sd_rd_busy & (req_wr | req_rd);
    assign w_pick_wr    = req_wr & (~req_rd | (last_grant_q == c_READ));
    assign w_sel_busy   = (sel_q == c_READ) ? sd_rd_busy : sd_wr_busy;
    assign w_sel_busy_q = (sel_q == c_READ) ? rd_busy_q  : wr_busy_q;
    assign w_rise       = w_sel_busy & ~w_sel_busy_q;
    assign w_fall       = ~w_sel_busy & w_sel_busy_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            sel_q        <= c_WRITE;
            last_grant_q <= c_READ;
            cnt_q        <= 24'd0;
            wr_busy_q    <= 1'b0;
            rd_busy_q    <= 1'b0;
            sd_wr_en_q   <= 1'b0;
            sd_rd_en_q   <= 1'b0;
            sd_wr_addr_q <= 32'd0;
            sd_rd_addr_q <= 32'd0;
            wr_done_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            rd_done_q    <= 1'b0;
            rd_err_q     <= 1'b0;
            arb_busy_q   <= 1'b0;
        end else begin
            wr_busy_q  <= sd_wr_busy;
            rd_busy_q  <= sd_rd_busy;
            sd_wr_en_q <= 1'b0;
            sd_rd_en_q <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_grant_ok) begin
                        if (w_pick_wr) begin
                            sel_q        <= c_WRITE;
                            last_grant_q <= c_WRITE;
                            sd_wr_addr_q <= req_wr_addr;
                            sd_wr_en_q   <= 1'b1;
                        end else begin
                            sel_q        <= c_READ;
                            last_grant_q <= c_READ;
                            sd_rd_addr_q <= req_rd_addr;
                            sd_rd_en_q   <= 1'b1;
                        end
                        arb_busy_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= 24'd0;
                    state_q <= S_ACK_WAIT;
                end
                S_ACK_WAIT: begin
                    if (w_rise) begin
                        cnt_q   <= 24'd0;
                        state_q <= S_BUSY_WAIT;
                    end else if (cnt_q == c_START_LAST) begin
                        wr_err_q <= (sel_q == c_WRITE);
                        rd_err_q <= (sel_q == c_READ);
                        state_q  <= S_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                S_BUSY_WAIT: begin
                    if (w_fall) begin
                        wr_done_q <= (sel_q == c_WRITE);
                        rd_done_q <= (sel_q == c_READ);
                        state_q   <= S_FINISH;
                    end else if (cnt_q == c_BUSY_LAST) begin
                        wr_err_q <= (sel_q == c_WRITE);
                        rd_err_q <= (sel_q == c_READ);
                        state_q  <= S_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                S_FINISH: begin
                    arb_busy_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    arb_busy_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign sd_wr_en   = sd_wr_en_q;
    assign sd_rd_en   = sd_rd_en_q;
    assign sd_wr_addr = sd_wr_addr_q;
    assign sd_rd_addr = sd_rd_addr_q;
    assign wr_done    = wr_done_q;
    assign wr_err     = wr_err_q;
    assign rd_done    = rd_done_q;
    assign rd_err     = rd_err_q;
    assign arb_busy   = arb_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_rw_arbiter
// Brief    : Bench for sd_rw_arbiter: deadline-based reference model checked
//            every cycle, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_rw_arbiter;

    localparam int S_MAX = 16;
    localparam int B_MAX = 100;
    localparam int BIG   = 1 << 30;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        init_end;
    logic        req_wr;
    logic [31:0] req_wr_addr;
    logic        req_rd;
    logic [31:0] req_rd_addr;
    logic        sd_wr_en;
    logic [31:0] sd_wr_addr;
    logic        sd_wr_busy;
    logic        sd_rd_en;
    logic [31:0] sd_rd_addr;
    logic        sd_rd_busy;
    logic        wr_done;
    logic        wr_err;
    logic        rd_done;
    logic        rd_err;
    logic        arb_busy;

    always #5 clk = ~clk;

    sd_rw_arbiter #(
        .START_WAIT_MAX(16'd16),
        .BUSY_WAIT_MAX (24'd100)
    ) u_dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .init_end   (init_end),
        .req_wr     (req_wr),
        .req_wr_addr(req_wr_addr),
        .req_rd     (req_rd),
        .req_rd_addr(req_rd_addr),
        .sd_wr_en   (sd_wr_en),
        .sd_wr_addr (sd_wr_addr),
        .sd_wr_busy (sd_wr_busy),
        .sd_rd_en   (sd_rd_en),
        .sd_rd_addr (sd_rd_addr),
        .sd_rd_busy (sd_rd_busy),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .rd_done    (rd_done),
        .rd_err     (rd_err),
        .arb_busy   (arb_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a transaction is described by its strobe cycle and the
    // cycle its result is reported, derived from elapsed-cycle deadlines.
    bit          m_valid = 1'b0;
    int          m_cyc = 0;
    bit          m_txn, m_own, m_last, m_acked, m_ok, m_fin, m_b, m_pb;
    bit          m_prev_wr, m_prev_rd;
    int          m_t_strobe, m_t_report, m_busy_start;
    logic [31:0] m_wr_addr, m_rd_addr;
    logic [6:0]  exp_ctl;

    initial begin
        forever begin
            @(posedge clk);
            if (sys_rst) begin
                m_valid    = 1'b1;
                m_txn      = 1'b0;
                m_last     = 1'b1;
                m_wr_addr  = 32'd0;
                m_rd_addr  = 32'd0;
                m_t_strobe = -1;
                m_t_report = -1;
            end else if (m_txn) begin
                if (m_cyc == m_t_report) begin
                    m_txn = 1'b0;
                end else if (m_cyc > m_t_strobe && m_t_report < 0) begin
                    m_b  = m_own ? sd_rd_busy : sd_wr_busy;
                    m_pb = m_own ? m_prev_rd : m_prev_wr;
                    if (!m_acked) begin
                        if (m_b && !m_pb) begin
                            m_acked      = 1'b1;
                            m_busy_start = m_cyc + 1;
                        end else if (m_cyc - m_t_strobe == S_MAX) begin
                            m_t_report = m_cyc + 1;
                            m_ok       = 1'b0;
                        end
                    end else begin
                        if (!m_b && m_pb) begin
                            m_t_report = m_cyc + 1;
                            m_ok       = 1'b1;
                        end else if (m_cyc - m_busy_start + 1 == B_MAX) begin
                            m_t_report = m_cyc + 1;
                            m_ok       = 1'b0;
                        end
                    end
                end
            end else if (init_end && !sd_wr_busy && !sd_rd_busy && (req_wr || req_rd)) begin
                m_own  = (req_wr && req_rd) ? !m_last : req_rd;
                m_last = m_own;
                if (m_own) m_rd_addr = req_rd_addr;
                else       m_wr_addr = req_wr_addr;
                m_txn      = 1'b1;
                m_acked    = 1'b0;
                m_t_strobe = m_cyc + 1;
                m_t_report = -1;
            end
            m_prev_wr = sd_wr_busy;
            m_prev_rd = sd_rd_busy;
            m_cyc++;
            m_fin   = m_txn && (m_cyc == m_t_report);
            exp_ctl = {m_txn && !m_own && (m_cyc == m_t_strobe),
                       m_txn &&  m_own && (m_cyc == m_t_strobe),
                       m_fin && !m_own &&  m_ok, m_fin && !m_own && !m_ok,
                       m_fin &&  m_own &&  m_ok, m_fin &&  m_own && !m_ok,
                       m_txn};
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_checks++;
                if ({sd_wr_en, sd_rd_en, wr_done, wr_err, rd_done, rd_err, arb_busy} !== exp_ctl) begin
                    n_errors++;
                    $display("FAIL ctl @%0d: got %b expected %b", m_cyc,
                             {sd_wr_en, sd_rd_en, wr_done, wr_err, rd_done, rd_err, arb_busy}, exp_ctl);
                end
                n_checks++;
                if (sd_wr_addr !== m_wr_addr || sd_rd_addr !== m_rd_addr) begin
                    n_errors++;
                    $display("FAIL addr @%0d: got wr=%h rd=%h expected wr=%h rd=%h", m_cyc,
                             sd_wr_addr, sd_rd_addr, m_wr_addr, m_rd_addr);
                end
            end
        end
    end

    // Emulated requesters and SD controller
    int          tcyc = 0;
    bit          hold_mode = 1'b0, auto_rand = 1'b0, rand_ctl = 1'b0;
    int          wr_delay, wr_hold, rd_delay, rd_hold;
    int          wr_rise_at, wr_fall_at, rd_rise_at, rd_fall_at, wr_noise_end, rd_noise_end;
    bit          cap_wr_en, cap_rd_en, cap_wr_fin, cap_rd_fin;
    int          obs_wr_en, obs_rd_en, obs_wr_done, obs_wr_err, obs_rd_done, obs_rd_err;
    int          cnt_fin, cnt_rd_en, cnt_arb;
    logic [31:0] addr_at_wr_en, addr_at_rd_en;
    bit          grant_q[$];

    task automatic clear_obs();
        obs_wr_en = -1; obs_rd_en = -1; obs_wr_done = -1;
        obs_wr_err = -1; obs_rd_done = -1; obs_rd_err = -1;
        cnt_fin = 0; cnt_rd_en = 0; cnt_arb = 0;
        grant_q.delete();
    endtask

    task automatic step();
        @(negedge clk);
        cap_wr_en  = sd_wr_en;
        cap_rd_en  = sd_rd_en;
        cap_wr_fin = wr_done | wr_err;
        cap_rd_fin = rd_done | rd_err;
        if (sd_wr_en) begin obs_wr_en = tcyc; addr_at_wr_en = sd_wr_addr; grant_q.push_back(1'b0); end
        if (sd_rd_en) begin obs_rd_en = tcyc; addr_at_rd_en = sd_rd_addr; grant_q.push_back(1'b1); cnt_rd_en++; end
        if (wr_done) obs_wr_done = tcyc;
        if (wr_err)  obs_wr_err  = tcyc;
        if (rd_done) obs_rd_done = tcyc;
        if (rd_err)  obs_rd_err  = tcyc;
        if (cap_wr_fin || cap_rd_fin) cnt_fin++;
        if (arb_busy) cnt_arb++;
        @(posedge clk);
        #1;
        tcyc++;
        if (cap_wr_en) begin
            if (rand_ctl) begin
                wr_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 18));
                wr_hold  = int'($urandom_range(2, 110));
            end
            wr_rise_at = (wr_delay < 0) ? BIG : tcyc - 1 + wr_delay;
            wr_fall_at = (wr_delay < 0 || wr_hold < 0) ? BIG : wr_rise_at + wr_hold;
        end
        if (cap_rd_en) begin
            if (rand_ctl) begin
                rd_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 18));
                rd_hold  = int'($urandom_range(2, 110));
            end
            rd_rise_at = (rd_delay < 0) ? BIG : tcyc - 1 + rd_delay;
            rd_fall_at = (rd_delay < 0 || rd_hold < 0) ? BIG : rd_rise_at + rd_hold;
        end
        if (auto_rand) begin
            if (tcyc >= wr_noise_end && $urandom_range(0, 299) == 0) wr_noise_end = tcyc + int'($urandom_range(2, 4));
            if (tcyc >= rd_noise_end && $urandom_range(0, 299) == 0) rd_noise_end = tcyc + int'($urandom_range(2, 4));
        end
        sd_wr_busy = (tcyc >= wr_rise_at && tcyc < wr_fall_at) || (tcyc < wr_noise_end);
        sd_rd_busy = (tcyc >= rd_rise_at && tcyc < rd_fall_at) || (tcyc < rd_noise_end);
        if (cap_wr_fin && !hold_mode) req_wr = 1'b0;
        else if (auto_rand && !req_wr && $urandom_range(0, 7) == 0) begin
            req_wr = 1'b1; req_wr_addr = $urandom;
        end
        if (cap_rd_fin && !hold_mode) req_rd = 1'b0;
        else if (auto_rand && !req_rd && $urandom_range(0, 7) == 0) begin
            req_rd = 1'b1; req_rd_addr = $urandom;
        end
        if (auto_rand) begin
            if (init_end && $urandom_range(0, 299) == 0)       init_end = 1'b0;
            else if (!init_end && $urandom_range(0, 19) == 0)  init_end = 1'b1;
            sys_rst = ($urandom_range(0, 599) == 0);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; req_wr = 1'b0; req_rd = 1'b0;
        wr_rise_at = BIG; wr_fall_at = BIG; rd_rise_at = BIG; rd_fall_at = BIG;
        wr_noise_end = 0; rd_noise_end = 0;
        sd_wr_busy = 1'b0; sd_rd_busy = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
        clear_obs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; init_end = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
        req_wr_addr = 32'd0; req_rd_addr = 32'd0; sd_wr_busy = 1'b0; sd_rd_busy = 1'b0;
        wr_delay = 3; wr_hold = 50; rd_delay = 3; rd_hold = 50;
        do_reset();
        chk("reset_ctl", longint'({sd_wr_en, sd_rd_en, wr_done, wr_err, rd_done, rd_err, arb_busy}), 0);
        chk("reset_addr", longint'({sd_wr_addr, sd_rd_addr}), 0);

        // Single write: busy rises 3 cycles after the strobe and holds 50 cycles
        init_end = 1'b1; wr_delay = 3; wr_hold = 50;
        begin
            int grant_cyc;
            grant_cyc = tcyc;
            req_wr = 1'b1; req_wr_addr = 32'd1000;
            for (int i = 0; i < 200 && obs_wr_done < 0; i++) step();
            chk("t1_strobe_latency", longint'(obs_wr_en - grant_cyc), 1);
        end
        chk("t1_wr_addr", longint'(addr_at_wr_en), 1000);
        chk("t1_done_latency", longint'(obs_wr_done - obs_wr_en), 54);
        chk("t1_no_err", longint'(obs_wr_err), -1);
        chk("t1_arb_idle", longint'(arb_busy), 0);

        // Round robin with both requests held continuously
        do_reset();
        init_end = 1'b1; hold_mode = 1'b1;
        wr_delay = 2; wr_hold = 5; rd_delay = 2; rd_hold = 5;
        req_wr = 1'b1; req_wr_addr = 32'h0000_0A0A;
        req_rd = 1'b1; req_rd_addr = 32'h0000_0B0B;
        for (int i = 0; i < 400 && grant_q.size() < 4; i++) step();
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_grant%0d", k), (k < grant_q.size()) ? longint'(grant_q[k]) : 2, k % 2);
        chk("t2_rd_addr", longint'(addr_at_rd_en), 32'h0000_0B0B);
        hold_mode = 1'b0;

        // Grants gated by init_end
        do_reset();
        init_end = 1'b0; rd_delay = 2; rd_hold = 4;
        req_rd = 1'b1; req_rd_addr = 32'h0000_0077;
        repeat (100) step();
        chk("t3_no_strobe", longint'(cnt_rd_en), 0);
        chk("t3_no_arb_busy", longint'(cnt_arb), 0);
        begin
            int rise_cyc;
            rise_cyc = tcyc;
            init_end = 1'b1;
            for (int i = 0; i < 20 && obs_rd_en < 0; i++) step();
            chk("t3_init_to_strobe", longint'(obs_rd_en - rise_cyc), 1);
        end

        // Start-acknowledge timeout: busy never rises
        do_reset();
        init_end = 1'b1; wr_delay = -1; wr_hold = 5;
        req_wr = 1'b1; req_wr_addr = 32'h0000_1234;
        for (int i = 0; i < 100 && obs_wr_err < 0; i++) step();
        chk("t4_err_latency", longint'(obs_wr_err - obs_wr_en), 17);
        chk("t4_no_done", longint'(obs_wr_done), -1);
        chk("t4_arb_idle", longint'(arb_busy), 0);

        // Busy timeout with busy stuck high, then grant blocked until release
        do_reset();
        init_end = 1'b1; rd_delay = 2; rd_hold = -1;
        req_rd = 1'b1; req_rd_addr = 32'h0000_55AA;
        for (int i = 0; i < 300 && obs_rd_err < 0; i++) step();
        chk("t5_err_latency", longint'(obs_rd_err - obs_rd_en), 103);
        chk("t5_no_done", longint'(obs_rd_done), -1);
        wr_delay = 2; wr_hold = 3;
        req_wr = 1'b1; req_wr_addr = 32'h0000_0099;
        repeat (20) step();
        chk("t5_blocked", longint'(obs_wr_en), -1);
        begin
            int low_cyc;
            low_cyc = tcyc + 1;
            rd_fall_at = low_cyc;
            for (int i = 0; i < 20 && obs_wr_en < 0; i++) step();
            chk("t5_release_strobe", longint'(obs_wr_en - low_cyc), 1);
        end

        // Reset during busy wait, then the still-pending write is re-granted
        do_reset();
        init_end = 1'b1; wr_delay = 2; wr_hold = 40;
        req_wr = 1'b1; req_wr_addr = 32'h0000_ABCD;
        for (int i = 0; i < 20 && obs_wr_en < 0; i++) step();
        repeat (10) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("t6_reset_ctl", longint'({sd_wr_en, sd_rd_en, wr_done, wr_err, rd_done, rd_err, arb_busy}), 0);
        chk("t6_reset_addr", longint'({sd_wr_addr, sd_rd_addr}), 0);
        clear_obs();
        for (int i = 0; i < 100 && obs_wr_en < 0; i++) step();
        chk("t6_no_pulse_before_regrant", longint'(cnt_fin), 0);
        chk("t6_regrant_addr", longint'(addr_at_wr_en), 32'h0000_ABCD);
        for (int i = 0; i < 100 && obs_wr_done < 0; i++) step();
        chk("t6_regrant_done", longint'(obs_wr_done > obs_wr_en), 1);

        // Randomized traffic
        do_reset();
        init_end = 1'b1; auto_rand = 1'b1; rand_ctl = 1'b1;
        repeat (4000) step();
        auto_rand = 1'b0; rand_ctl = 1'b0; sys_rst = 1'b0;
        chk("rand_activity", longint'(cnt_fin > 20), 1);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
